// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO; 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Async active-low reset; TxD is driven straight from a flop so it never glitches.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       WR,
    input  logic [7:0] dataIn,
    output logic       TxD,
    output logic       EMPTY,
    output logic       FULL,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic [BW-1:0] r_baud;
    logic          r_txd;
    logic          r_busy;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_baud_end;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr_en    = WR && !w_full;
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_pop      = !w_empty &&
                        ((r_state == IDLE) ||
                         ((r_state == STOP) && w_baud_end));
    assign w_head     = r_mem[r_rptr[AW-1:0]];

    assign TxD   = r_txd;
    assign busy  = r_busy;
    assign EMPTY = w_empty;
    assign FULL  = w_full;

    // Storage is left uncleared on reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state  <= START;
                        r_txd    <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_state   <= DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        // Chain straight into the next frame when data waits.
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state  <= START;
                            r_txd    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Each sample index is one negedge; a write issued at index 0 starts its frame at index 2.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       reset;
    logic       WR;
    logic [7:0] dataIn;
    logic       TxD;
    logic       EMPTY;
    logic       FULL;
    logic       busy;

    int checks;
    int failures;

    logic       qt[$];
    logic       qb[$];
    logic       qe[$];
    logic       qf[$];
    logic       ex[$];
    logic [7:0] wdat[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .WR    (WR),
        .dataIn(dataIn),
        .TxD   (TxD),
        .EMPTY (EMPTY),
        .FULL  (FULL),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic wr, input logic [7:0] d);
        @(negedge clk);
        qt.push_back(TxD);
        qb.push_back(busy);
        qe.push_back(EMPTY);
        qf.push_back(FULL);
        WR     = wr;
        dataIn = d;
    endtask

    task automatic clear_all();
        qt.delete();
        qb.delete();
        qe.delete();
        qf.delete();
        ex.delete();
        wdat.delete();
    endtask

    task automatic add_level(input logic v, input int n);
        for (int i = 0; i < n; i++) ex.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b);
        add_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) add_level(b[i], CPB);
`ifdef UART_TX_PARITY_EN
        add_level(^b, CPB);
`endif
        add_level(1'b1, CPB);
    endtask

    task automatic run_stream();
        for (int i = 0; i < ex.size(); i++) begin
            if (i < wdat.size()) cycle(1'b1, wdat[i]);
            else cycle(1'b0, 8'h00);
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < ex.size(); i++) begin
            if (i >= qt.size()) return i;
            if (qt[i] !== ex[i]) return i;
        end
        return -1;
    endfunction

    function automatic int count_busy();
        int n = 0;
        foreach (qb[i]) if (qb[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset  = 1'b0;
        WR     = 1'b0;
        dataIn = 8'h00;
        repeat (3) @(negedge clk);
        checks += 4;
        if (TxD !== 1'b1) begin
            failures++;
            $display("FAIL reset_txd got=%b exp=1", TxD);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty got=%b exp=1", EMPTY);
        end
        if (FULL !== 1'b0) begin
            failures++;
            $display("FAIL reset_full got=%b exp=0", FULL);
        end
        reset = 1'b1;
        clear_all();
        cycle(1'b1, 8'h5A);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        checks++;
        if (qt[2] !== 1'b0) begin
            failures++;
            $display("FAIL start_bit got=%b exp=0", qt[2]);
        end
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (TxD !== 1'b1) begin
            failures++;
            $display("FAIL async_txd got=%b exp=1", TxD);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL async_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_byte();
        int d;
        int nb;
        clear_all();
        wdat.push_back(8'hA5);
        add_level(1'b1, 2);
        add_frame(8'hA5);
        add_level(1'b1, 4);
        run_stream();
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL single_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
        nb = count_busy();
        checks++;
        if (nb != FB * CPB) begin
            failures++;
            $display("FAIL single_busy_cycles got=%0d exp=%0d", nb, FB * CPB);
        end
        checks += 3;
        if (qe[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_empty0 got=%b exp=1", qe[0]);
        end
        if (qe[1] !== 1'b0) begin
            failures++;
            $display("FAIL single_empty1 got=%b exp=0", qe[1]);
        end
        if (qe[2] !== 1'b1) begin
            failures++;
            $display("FAIL single_empty2 got=%b exp=1", qe[2]);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int nb;
        clear_all();
        wdat.push_back(8'h00);
        wdat.push_back(8'hFF);
        wdat.push_back(8'h55);
        add_level(1'b1, 2);
        add_frame(8'h00);
        add_frame(8'hFF);
        add_frame(8'h55);
        add_level(1'b1, 4);
        run_stream();
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL b2b_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
        nb = count_busy();
        checks++;
        if (nb != 3 * FB * CPB) begin
            failures++;
            $display("FAIL b2b_busy_cycles got=%0d exp=%0d", nb, 3 * FB * CPB);
        end
    endtask

    task automatic test_full_overflow();
        int d;
        clear_all();
        for (int i = 0; i < 6; i++) wdat.push_back(8'h10 + 8'(i));
        add_level(1'b1, 2);
        for (int i = 0; i < 5; i++) add_frame(8'h10 + 8'(i));
        add_level(1'b1, 6);
        run_stream();
        checks += 4;
        if (qf[4] !== 1'b0) begin
            failures++;
            $display("FAIL full_before got=%b exp=0", qf[4]);
        end
        if (qf[5] !== 1'b1) begin
            failures++;
            $display("FAIL full_set got=%b exp=1", qf[5]);
        end
        if (qf[6] !== 1'b1) begin
            failures++;
            $display("FAIL full_after_drop got=%b exp=1", qf[6]);
        end
        if (qe[qe.size()-1] !== 1'b1) begin
            failures++;
            $display("FAIL full_drained got=%b exp=1", qe[qe.size()-1]);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL full_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        int d;
        clear_all();
        cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        for (int i = 3; i < 20; i++) cycle(1'b0, 8'h00);
        checks += 2;
        if (qt[19] !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit3 got=%b exp=1", qt[19]);
        end
        if (qe[19] !== 1'b0) begin
            failures++;
            $display("FAIL mid_queued got=%b exp=0", qe[19]);
        end
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (TxD !== 1'b1) begin
            failures++;
            $display("FAIL mid_txd got=%b exp=1", TxD);
        end
        if (EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL mid_empty got=%b exp=1", EMPTY);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=0", busy);
        end
        if (FULL !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got=%b exp=0", FULL);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_all();
        for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
        bad = 0;
        for (int i = 0; i < 60; i++)
            if (qt[i] !== 1'b1 || qb[i] !== 1'b0 || qe[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_reset_idle got=%0d bad samples exp=0", bad);
        end
        clear_all();
        wdat.push_back(8'h81);
        add_level(1'b1, 2);
        add_frame(8'h81);
        add_level(1'b1, 4);
        run_stream();
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL resume_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int d;
        clear_all();
        wdat.push_back(8'h07);
        add_level(1'b1, 2);
        add_frame(8'h07);
        add_level(1'b1, 4);
        run_stream();
        d = first_diff();
        checks += 2;
        if (qt[2 + 9 * CPB] !== 1'b1) begin
            failures++;
            $display("FAIL parity_07 got=%b exp=1", qt[2 + 9 * CPB]);
        end
        if (d != -1) begin
            failures++;
            $display("FAIL parity_07_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
        clear_all();
        wdat.push_back(8'h03);
        add_level(1'b1, 2);
        add_frame(8'h03);
        add_level(1'b1, 4);
        run_stream();
        d = first_diff();
        checks += 2;
        if (qt[2 + 9 * CPB] !== 1'b0) begin
            failures++;
            $display("FAIL parity_03 got=%b exp=0", qt[2 + 9 * CPB]);
        end
        if (d != -1) begin
            failures++;
            $display("FAIL parity_03_stream idx=%0d got=%b exp=%b",
                     d, (d < qt.size()) ? qt[d] : 1'bx, ex[d]);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_overflow();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200); legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning FIFO entries; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port WR, input, 1 bit: write strobe; one byte per high cycle.
REQ-006 SHALL have port dataIn, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port TxD, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port EMPTY, output, 1 bit: FIFO holds 0 entries.
REQ-009 SHALL have port FULL, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL write dataIn into the FIFO on a clk edge with WR=1 and FULL=0.
- WR with FULL=1 is dropped, with no state change.
- This holds even if a pop occurs in the same cycle.
REQ-012 SHALL keep FIFO write and read pointers log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH.
- EMPTY = pointers equal.
- FULL = MSBs differ and the remaining bits are equal.
REQ-013 SHALL allow a write and a pop in the same cycle when 0 < count < FIFO_DEPTH; count is then unchanged.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE with EMPTY=0, pop the head byte into an 8-bit shift register and enter START on the same edge.
- TxD goes to 0 one cycle after EMPTY first reads 0.
REQ-016 SHALL hold each bit on TxD for exactly CLKS_PER_BIT cycles, using a baud counter cleared on every state or bit transition.
REQ-017 SHALL send START=0, then DATA as 8 bits LSB first, tracked by a 3-bit bit index, then STOP=1.
REQ-018 SHALL, at the end of STOP, go directly to START with a new pop if EMPTY=0 (no idle gap between frames); otherwise it goes to IDLE.
REQ-019 SHALL drive TxD=1 in IDLE and STOP.
REQ-020 SHALL keep TxD free of glitches by driving it from a register.
REQ-021 SHALL ignore changes to dataIn and WR for a frame already in progress; the shift register is isolated from the FIFO after the pop.

Reset
REQ-022 SHALL, while reset=0, asynchronously force:
- FSM=IDLE;
- TxD=1, busy=0;
- pointers=0, so EMPTY=1 and FULL=0;
- baud counter=0, bit index=0.
REQ-023 SHALL discard any partial frame and all queued bytes on reset assertion mid-frame.
- TxD returns to 1 immediately, without waiting for a clock.
REQ-024 SHALL resume normal operation on the first clk edge after reset deasserts; FIFO contents need no clearing.

Configuration
REQ-025 SHALL honour macro UART_TX_PARITY_EN.
- When defined: the PARITY state is inserted between DATA and STOP. It drives the XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, giving 11-bit frames.
- When undefined: PARITY is unreachable and omitted, giving 10-bit frames of 10*CLKS_PER_BIT cycles.

Verification
REQ-026 Single byte (CLKS_PER_BIT=4, parity off): write 0xA5 once -> TxD = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles; EMPTY back to 1 one cycle after the write+1.
REQ-027 Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> 30 contiguous bit periods with no idle cycle; decoded bytes are 0x00, 0xFF, 0x55 in that order.
REQ-028 Full and overflow (FIFO_DEPTH=4, TX stalled by reset deassert timing): write 6 bytes 0x10..0x15 in one burst -> FULL asserts; 0x15 is dropped (and 0x14 too, if no pop has occurred); serial output contains only the accepted bytes, in order.
REQ-029 Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued -> TxD=1 and EMPTY=1 asynchronously; no further frames after release until a new write.
REQ-030 Parity (UART_TX_PARITY_EN defined): write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; each frame is 11 bit periods.
